// File: rtl/fanin_tree_pipe.sv
// fanin_tree_pipe: pipelined N-to-1 binary reduction tree (AND/OR/XOR/ADD) with valid/ready on both ends
//   clk       rising-edge clock
//   rst       synchronous active-high reset; discards everything in flight
//   in_valid  / in_ready   input handshake; in_ready is combinational from out_ready
//   in_data   NUM_IN lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//   in_mode   0=AND 1=OR 2=XOR 3=ADD, carried with the data through the pipe
//   out_valid / out_ready  output handshake
//   out_data  WIDTH+LEVELS-bit reduction result
//   out_mode  mode of the transaction on out_data
module fanin_tree_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 8,
    localparam int LEVELS = $clog2(NUM_IN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_IN*WIDTH-1:0]    in_data,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH+LEVELS-1:0]    out_data,
    output logic [1:0]                 out_mode
);
    localparam int OW = WIDTH + LEVELS;
    localparam logic [OW-1:0] LOGIC_MASK = {{LEVELS{1'b0}}, {WIDTH{1'b1}}};

    // Heap layout: node n has children 2n and 2n+1; leaves NUM_IN..2*NUM_IN-1 are the
    // input lanes and node 1 is the root. Every value is carried at full output width;
    // a level-k node only ever uses its low WIDTH+k bits, the rest stay zero.
    logic [OW-1:0]        tree [1:2*NUM_IN-1];
    logic [LEVELS:1]      valid_q, valid_d;
    logic [LEVELS:1][1:0] mode_q, mode_d;
    logic [LEVELS:1]      rdy;
    logic [LEVELS-1:0]      src_v;
    logic [LEVELS-1:0][1:0] src_m;

    function automatic logic [OW-1:0] combine(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                              input logic [1:0] m);
        return (m == 2'd3) ? a + b
             : LOGIC_MASK & ((m == 2'd0) ? (a & b) : (m == 2'd1) ? (a | b) : (a ^ b));
    endfunction

    // Stage k may load when it is empty or anything downstream can move; unrolling the
    // stall chain gives an OR over the empty flags of stages k..LEVELS and out_ready.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_rdy
        assign rdy[k] = out_ready || !(&valid_q[LEVELS:k]);
    end

    // Source of stage k is stage k-1; index 0 is the input port.
    always_comb begin
        src_v[0] = in_valid;
        src_m[0] = in_mode;
        for (int k = 1; k < LEVELS; k++) begin
            src_v[k] = valid_q[k];
            src_m[k] = mode_q[k];
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_leaf
        assign tree[NUM_IN+i] = {{LEVELS{1'b0}}, in_data[i*WIDTH +: WIDTH]};
    end

    for (genvar n = 1; n < NUM_IN; n++) begin : g_node
        localparam int K = LEVELS + 1 - $clog2(n + 1);
        logic [OW-1:0] node_q, node_d;
        assign node_d = (rdy[K] && src_v[K-1]) ? combine(tree[2*n], tree[2*n+1], src_m[K-1]) : node_q;
        always_ff @(posedge clk) begin
            if (rst) node_q <= '0;
            else     node_q <= node_d;
        end
        assign tree[n] = node_q;
    end

    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        for (int k = 1; k <= LEVELS; k++) begin
            valid_d[k] = rdy[k] ? src_v[k-1] : valid_q[k];
            mode_d[k]  = (rdy[k] && src_v[k-1]) ? src_m[k-1] : mode_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            mode_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = rdy[1];
    assign out_valid = valid_q[LEVELS];
    assign out_mode  = mode_q[LEVELS];
    assign out_data  = tree[1];
endmodule

// File: tb/tb_fanin_tree_pipe.sv
// tb_fanin_tree_pipe: directed checks of the 8x8 tree and a 2x4 instance
module tb_fanin_tree_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data;
    logic [1:0]  in_mode, out_mode;
    logic [10:0] out_data;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [7:0]  in_data_b;
    logic [1:0]  in_mode_b, out_mode_b;
    logic [4:0]  out_data_b;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fanin_tree_pipe #(.WIDTH(8), .NUM_IN(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode));

    fanin_tree_pipe #(.WIDTH(4), .NUM_IN(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .in_mode(in_mode_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_mode(out_mode_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] lanes(input logic [7:0] v);
        return {8{v}};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; in_mode_b = 2'd0; out_ready_b = 1'b1;
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        chk("rst_b_out_valid", 32'(out_valid_b), 32'd0);
        chk("rst_b_out_data", 32'(out_data_b), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // ADD with all lanes at max, exact 3-cycle latency
        in_valid = 1'b1; in_data = lanes(8'hFF); in_mode = 2'd3;
        cyc();
        in_valid = 1'b0; in_data = lanes(8'h55); in_mode = 2'd0;
        chk("add_lat1", 32'(out_valid), 32'd0);
        cyc();
        chk("add_lat2", 32'(out_valid), 32'd0);
        cyc();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_data", 32'(out_data), 32'h7F8);
        chk("add_mode", 32'(out_mode), 32'd3);
        cyc();
        chk("add_drained", 32'(out_valid), 32'd0);

        // AND, OR, XOR back-to-back on one-hot lanes
        in_valid = 1'b1; in_data = 64'h8040201008040201; in_mode = 2'd0;
        cyc();
        in_mode = 2'd1;
        cyc();
        in_mode = 2'd2;
        cyc();
        in_valid = 1'b0;
        chk("and_valid", 32'(out_valid), 32'd1);
        chk("and_data", 32'(out_data), 32'h000);
        chk("and_mode", 32'(out_mode), 32'd0);
        cyc();
        chk("or_data", 32'(out_data), 32'h0FF);
        chk("or_mode", 32'(out_mode), 32'd1);
        cyc();
        chk("xor_data", 32'(out_data), 32'h0FF);
        chk("xor_mode", 32'(out_mode), 32'd2);
        cyc();
        chk("logic_drained", 32'(out_valid), 32'd0);

        // Backpressure: fill with out_ready low, then pop and push in one cycle
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd3; in_data = lanes(8'd1);
        #1 chk("bp_ready0", 32'(in_ready), 32'd1);
        cyc();
        in_data = lanes(8'd2);
        #1 chk("bp_ready1", 32'(in_ready), 32'd1);
        cyc();
        in_data = lanes(8'd3);
        #1 chk("bp_ready2", 32'(in_ready), 32'd1);
        cyc();
        in_data = lanes(8'd4);
        #1 chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_head_valid", 32'(out_valid), 32'd1);
        chk("bp_head_data", 32'(out_data), 32'd8);
        cyc();
        chk("bp_hold_data1", 32'(out_data), 32'd8);
        chk("bp_hold_mode", 32'(out_mode), 32'd3);
        chk("bp_hold_full", 32'(in_ready), 32'd0);
        cyc();
        chk("bp_hold_data2", 32'(out_data), 32'd8);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_drain1", 32'(out_data), 32'd16);
        cyc();
        chk("bp_drain2", 32'(out_data), 32'd24);
        cyc();
        chk("bp_drain3_valid", 32'(out_valid), 32'd1);
        chk("bp_drain3", 32'(out_data), 32'd32);
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Bubble collapse behind a stalled head
        in_valid = 1'b1; in_data = lanes(8'd5);
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("bub_head_valid", 32'(out_valid), 32'd1);
        chk("bub_head_data", 32'(out_data), 32'd40);
        out_ready = 1'b0; in_valid = 1'b1; in_data = lanes(8'd6);
        #1 chk("bub_accept1", 32'(in_ready), 32'd1);
        cyc();
        in_data = lanes(8'd7);
        #1 chk("bub_accept2", 32'(in_ready), 32'd1);
        cyc();
        #1 chk("bub_full", 32'(in_ready), 32'd0);
        chk("bub_head_hold", 32'(out_data), 32'd40);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("bub_out2", 32'(out_data), 32'd48);
        cyc();
        chk("bub_out3", 32'(out_data), 32'd56);
        cyc();
        chk("bub_empty", 32'(out_valid), 32'd0);

        // Reset with two transactions in flight
        in_valid = 1'b1; in_data = lanes(8'd1);
        cyc();
        in_data = lanes(8'd2);
        cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_out", 32'(out_valid), 32'd0);
            cyc();
        end
        chk("midrst_ready", 32'(in_ready), 32'd1);

        // 2-lane, 4-bit instance: single-cycle latency
        in_valid_b = 1'b1; in_data_b = {4'h1, 4'hF}; in_mode_b = 2'd3;
        #1 chk("b_ready", 32'(in_ready_b), 32'd1);
        cyc();
        in_valid_b = 1'b0;
        chk("b_valid", 32'(out_valid_b), 32'd1);
        chk("b_data", 32'(out_data_b), 32'h10);
        chk("b_mode", 32'(out_mode_b), 32'd3);
        cyc();
        chk("b_empty", 32'(out_valid_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
